// File: rtl/pattern_det_pkg.sv
// Shared definitions for the serial pattern detector: size limits, overlap mode
// encoding and the suffix/prefix match-length helper used by the next-state logic.
package pattern_det_pkg;

  localparam int MAX_PAT_LEN = 16;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } overlap_mode_e;

  // Largest k (0..len) such that the newest k bits of {hist_bits, a} equal the
  // top k bits of pat. Bit 0 of the combined vector is the newest sample.
  function automatic logic [4:0] prefix_len(
    input logic [MAX_PAT_LEN-2:0] hist_bits,
    input logic                   a,
    input logic [MAX_PAT_LEN-1:0] pat,
    input int                     len
  );
    logic [MAX_PAT_LEN-1:0] seq;
    logic [MAX_PAT_LEN-1:0] mask;
    logic [MAX_PAT_LEN-1:0] diff;
    logic [4:0]             best;
    seq  = {hist_bits, a};
    best = '0;
    for (int k = 1; k <= MAX_PAT_LEN; k++) begin
      if (k <= len) begin
        mask = (k == MAX_PAT_LEN) ? '1 : MAX_PAT_LEN'((32'd1 << k) - 32'd1);
        diff = (seq ^ (pat >> (len - k))) & mask;
        if (diff == '0) begin
          best = 5'(k);
        end
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/pattern_detector_moore_match.sv
// Combinational next-state logic: computes the matched-prefix length for the
// next edge from the history, the incoming bit, the pattern and the overlap mode.
module pattern_prefix_match
  import pattern_det_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int SW      = $clog2(PAT_LEN + 1)
) (
  input  logic [PAT_LEN-1:0] seq,
  input  logic [PAT_LEN-1:0] pat,
  input  logic               overlap,
  input  logic [SW-1:0]      state,
  output logic [SW-1:0]      next_state,
  output logic               restart
);

  localparam int            HW       = MAX_PAT_LEN - 1;
  localparam logic [SW-1:0] MATCH_ST = SW'(PAT_LEN);

  logic [HW-1:0]          hist_pad;
  logic [MAX_PAT_LEN-1:0] pat_pad;

  assign hist_pad = HW'(seq[PAT_LEN-1:1]);
  assign pat_pad  = MAX_PAT_LEN'(pat);

  always_comb begin
    next_state = '0;
    restart    = 1'b0;
    if (state > MATCH_ST) begin
      next_state = '0;
    end else if (state == MATCH_ST && overlap == NON_OVERLAP) begin
      // The bits that formed the match are consumed; only the new bit counts.
      restart    = 1'b1;
      next_state = (seq[0] == pat[PAT_LEN-1]) ? SW'(1) : '0;
    end else begin
      next_state = SW'(prefix_len(hist_pad, seq[0], pat_pad, PAT_LEN));
    end
  end

endmodule

// File: rtl/pattern_detector_moore.sv
// Moore serial pattern detector: programmable PAT_LEN-bit pattern, MSB first,
// overlap/non-overlap modes, sample enable and a saturating hit counter.
module pattern_detector_moore
  import pattern_det_pkg::*;
#(
  parameter int                 PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0] RESET_PAT = PAT_LEN'(4'b0101),
  parameter int                 CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               a,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pattern_in,
  input  logic               overlap,
  input  logic               clr_count,
  output logic               y,
  output logic [CNT_W-1:0]   match_count
);

  localparam int            SW       = $clog2(PAT_LEN + 1);
  localparam int            HW       = PAT_LEN - 1;
  localparam logic [SW-1:0] MATCH_ST = SW'(PAT_LEN);

  logic [SW-1:0]      state;
  logic [SW-1:0]      state_d;
  logic [SW-1:0]      next_state;
  logic [HW-1:0]      hist;
  logic [HW-1:0]      hist_d;
  logic [PAT_LEN-1:0] pat_reg;
  logic [PAT_LEN-1:0] pat_d;
  logic [PAT_LEN-1:0] seq;
  logic [CNT_W-1:0]   count_d;
  logic               restart;

  assign seq = {hist, a};

  pattern_prefix_match #(
    .PAT_LEN (PAT_LEN),
    .SW      (SW)
  ) u_match (
    .seq        (seq),
    .pat        (pat_reg),
    .overlap    (overlap),
    .state      (state),
    .next_state (next_state),
    .restart    (restart)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= '0;
      hist        <= '0;
      pat_reg     <= RESET_PAT;
      match_count <= '0;
    end else begin
      state       <= state_d;
      hist        <= hist_d;
      pat_reg     <= pat_d;
      match_count <= count_d;
    end
  end

  always_comb begin
    state_d = state;
    hist_d  = hist;
    pat_d   = pat_reg;
    count_d = match_count;
    if (load) begin
      pat_d   = pattern_in;
      state_d = '0;
      hist_d  = '0;
    end else if (en) begin
      state_d = next_state;
      // A non-overlapping restart drops the matched bits from the history too.
      hist_d  = restart ? HW'(a) : seq[HW-1:0];
    end
    if (clr_count) begin
      count_d = '0;
    end else if (!load && en && next_state == MATCH_ST && match_count != '1) begin
      count_d = match_count + CNT_W'(1);
    end
  end

  assign y = (state == MATCH_ST);

endmodule
